// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types: MMU command bundle, in-flight read tag.
// Also holds the upper bound on requester count.
package mem_arb_pkg;

  localparam int MAX_NREQ = 4;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } MemCmd;

  typedef struct packed {
    logic       valid;
    logic [1:0] port;
  } ArbTag;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr.
// Ports: req (N), ptr (2) in; gnt (one-hot N), valid out.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic [N-1:0] gnt,
  output logic         valid
);

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!valid && req[j] &&
            j == ((int'(ptr) + i) % N)) begin
          gnt[j] = 1'b1;
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin MMU port arbiter with bounded lock and read-tag routing.
// Ports: clkin/reset_n; per-port req/lock/we/addr/wdata, gnt/rvalid;
// rdata; MMU side mem_valid/mem_w_en/mem_addr/mem_wdata/mem_rdata.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int MEM_LAT  = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clkin,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ-1:0][15:0] addr,
  input  logic [NREQ-1:0][15:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rvalid,
  output logic [15:0]           rdata,
  output logic                  mem_valid,
  output logic                  mem_w_en,
  output logic [15:0]           mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata
);

  localparam int HW  = $clog2(MAX_HOLD + 1);
  localparam int IDW = $clog2(MAX_NREQ);

  logic [IDW-1:0]  rr_ptr;
  logic [HW-1:0]   hold_cnt;
  logic            lk_act;
  logic [IDW-1:0]  lk_port;
  ArbTag           tags [MEM_LAT];

  logic [NREQ-1:0] p_mask;
  logic [NREQ-1:0] pick_req;
  logic [NREQ-1:0] pick_gnt;
  logic            pick_v;
  logic [NREQ-1:0] gnt_raw;
  logic            any;
  logic            hold_max;
  logic            keep;
  logic            excl;
  logic [IDW-1:0]  win;
  MemCmd           cmd;
  ArbTag           tl;

  always_comb begin
    p_mask = '0;
    for (int j = 0; j < NREQ; j++)
      p_mask[j] = (lk_port == IDW'(j));
  end

  assign hold_max = (hold_cnt == HW'(MAX_HOLD));
  // Locked port keeps the bus until its hold budget is spent.
  assign keep = lk_act && |(req & p_mask) && !hold_max;
  // Budget spent: one round-robin cycle that skips P if anyone else waits.
  assign excl = lk_act && hold_max && |(req & ~p_mask);
  assign pick_req = excl ? (req & ~p_mask) : req;

  rr_pick #(.N(NREQ)) u_pick (
    .req   (pick_req),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .valid (pick_v)
  );

  assign gnt_raw = keep ? p_mask : pick_gnt;
  assign any     = keep | pick_v;

  always_comb begin
    win = '0;
    cmd = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (gnt_raw[j]) begin
        win = IDW'(j);
        cmd = '{we[j], addr[j], wdata[j]};
      end
    end
  end

  // Outputs forced to 0 while reset is held, even with requests pending.
  assign gnt       = reset_n ? gnt_raw : '0;
  assign mem_valid = reset_n & any;
  assign mem_w_en  = mem_valid & cmd.we;
  assign mem_addr  = mem_valid ? cmd.addr : '0;
  assign mem_wdata = mem_valid ? cmd.wdata : '0;

  assign tl = tags[MEM_LAT-1];

  always_comb begin
    rvalid = '0;
    for (int j = 0; j < NREQ; j++)
      rvalid[j] = reset_n & tl.valid & (tl.port == IDW'(j));
  end

  assign rdata = (reset_n & tl.valid) ? mem_rdata : '0;

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      hold_cnt <= '0;
      lk_act   <= 1'b0;
      lk_port  <= '0;
    end else if (!any) begin
      hold_cnt <= '0;
      lk_act   <= 1'b0;
    end else begin
      rr_ptr  <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
      lk_act  <= lock[win];
      lk_port <= win;
      if (lk_act && hold_max)
        hold_cnt <= '0;
      else if (lock[win])
        hold_cnt <= (lk_act && win == lk_port) ?
                    hold_cnt + HW'(1) : HW'(1);
      else
        hold_cnt <= '0;
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MEM_LAT; i++)
        tags[i] <= '0;
    end else begin
      tags[0] <= '{any & ~cmd.we, win};
      for (int i = 1; i < MEM_LAT; i++)
        tags[i] <= tags[i-1];
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter (NREQ=2, MEM_LAT=2, MAX_HOLD=3).
// Table of per-cycle stimulus/expectations plus a reset-mid-read sequence.
module tb_mem_arbiter;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req = '0;
  logic [1:0]       lock = '0;
  logic [1:0]       we = '0;
  logic [1:0][15:0] addr = '0;
  logic [1:0][15:0] wdata = '0;
  logic [1:0]       gnt;
  logic [1:0]       rvalid;
  logic [15:0]      rdata;
  logic             mem_valid;
  logic             mem_w_en;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_wdata;
  logic [15:0]      mem_rdata = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .NREQ(2), .MEM_LAT(2), .MAX_HOLD(3)
  ) dut (
    .clkin     (clk),
    .reset_n   (rst_n),
    .req       (req),
    .lock      (lock),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_valid (mem_valid),
    .mem_w_en  (mem_w_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  typedef struct {
    logic [1:0]  req, lock, we;
    logic [15:0] a0, a1, d0, d1, mrd;
    logic [1:0]  gnt, rv;
    logic [15:0] rd;
    logic        mv, mwe;
    logic [15:0] ma, md;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input logic [1:0] r, l, w,
    input logic [15:0] a0, a1, d0, d1, mrd,
    input logic [1:0] g, rv,
    input logic [15:0] rd,
    input logic mv, mwe,
    input logic [15:0] ma, md);
    vec_t v;
    v.req = r; v.lock = l; v.we = w;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.mrd = mrd; v.gnt = g; v.rv = rv; v.rd = rd;
    v.mv = mv; v.mwe = mwe; v.ma = ma; v.md = md;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int step,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h",
               nm, step, act, exp);
    end
  endtask

  initial begin
    // idle / reset state
    add(2'b00,2'b00,2'b00,16'h0,16'h0,16'h0,16'h0,16'h0,
        2'b00,2'b00,16'h0,1'b0,1'b0,16'h0,16'h0);
    // single read port 0
    add(2'b01,2'b00,2'b00,16'h0040,16'h0,16'h0,16'h0,16'h0,
        2'b01,2'b00,16'h0,1'b1,1'b0,16'h0040,16'h0);
    add(2'b00,2'b00,2'b00,16'h0,16'h0,16'h0,16'h0,16'h1111,
        2'b00,2'b00,16'h0,1'b0,1'b0,16'h0,16'h0);
    add(2'b00,2'b00,2'b00,16'h0,16'h0,16'h0,16'h0,16'hBEEF,
        2'b00,2'b01,16'hBEEF,1'b0,1'b0,16'h0,16'h0);
    // contention, pipelined alternating reads (ptr at 1)
    add(2'b11,2'b00,2'b00,16'h0010,16'h0020,16'h0,16'h0,16'h0,
        2'b10,2'b00,16'h0,1'b1,1'b0,16'h0020,16'h0);
    add(2'b11,2'b00,2'b00,16'h0010,16'h0020,16'h0,16'h0,16'h0,
        2'b01,2'b00,16'h0,1'b1,1'b0,16'h0010,16'h0);
    add(2'b11,2'b00,2'b00,16'h0010,16'h0020,16'h0,16'h0,16'hA020,
        2'b10,2'b10,16'hA020,1'b1,1'b0,16'h0020,16'h0);
    add(2'b11,2'b00,2'b00,16'h0010,16'h0020,16'h0,16'h0,16'hA010,
        2'b01,2'b01,16'hA010,1'b1,1'b0,16'h0010,16'h0);
    add(2'b00,2'b00,2'b00,16'h0,16'h0,16'h0,16'h0,16'hB020,
        2'b00,2'b10,16'hB020,1'b0,1'b0,16'h0,16'h0);
    add(2'b00,2'b00,2'b00,16'h0,16'h0,16'h0,16'h0,16'hB010,
        2'b00,2'b01,16'hB010,1'b0,1'b0,16'h0,16'h0);
    add(2'b00,2'b00,2'b00,16'h0,16'h0,16'h0,16'h0,16'hC000,
        2'b00,2'b00,16'h0,1'b0,1'b0,16'h0,16'h0);
    // write port 1, no response follows
    add(2'b10,2'b00,2'b10,16'h0,16'h8000,16'h0,16'h1234,16'h0,
        2'b10,2'b00,16'h0,1'b1,1'b1,16'h8000,16'h1234);
    add(2'b00,2'b00,2'b00,16'h0,16'h0,16'h0,16'h0,16'hDEAD,
        2'b00,2'b00,16'h0,1'b0,1'b0,16'h0,16'h0);
    add(2'b00,2'b00,2'b00,16'h0,16'h0,16'h0,16'h0,16'hDEAD,
        2'b00,2'b00,16'h0,1'b0,1'b0,16'h0,16'h0);
    // lock bound: port 1 locks, grants 1,1,1,0,1
    add(2'b10,2'b10,2'b10,16'h0100,16'h0300,16'h0A0A,16'h5555,
        16'h0,2'b10,2'b00,16'h0,1'b1,1'b1,16'h0300,16'h5555);
    for (int k = 0; k < 2; k++)
      add(2'b11,2'b10,2'b11,16'h0100,16'h0300,16'h0A0A,16'h5555,
          16'h0,2'b10,2'b00,16'h0,1'b1,1'b1,16'h0300,16'h5555);
    add(2'b11,2'b10,2'b11,16'h0100,16'h0300,16'h0A0A,16'h5555,
        16'h0,2'b01,2'b00,16'h0,1'b1,1'b1,16'h0100,16'h0A0A);
    add(2'b11,2'b10,2'b11,16'h0100,16'h0300,16'h0A0A,16'h5555,
        16'h0,2'b10,2'b00,16'h0,1'b1,1'b1,16'h0300,16'h5555);
    // port 1 released: round robin resumes
    add(2'b01,2'b00,2'b11,16'h0100,16'h0300,16'h0A0A,16'h5555,
        16'h0,2'b01,2'b00,16'h0,1'b1,1'b1,16'h0100,16'h0A0A);
    add(2'b00,2'b00,2'b00,16'h0,16'h0,16'h0,16'h0,16'h0,
        2'b00,2'b00,16'h0,1'b0,1'b0,16'h0,16'h0);
    // lock without req ignored
    add(2'b01,2'b10,2'b01,16'h0100,16'h0,16'h0A0A,16'h0,16'h0,
        2'b01,2'b00,16'h0,1'b1,1'b1,16'h0100,16'h0A0A);
    // read from port 1 (ptr at 1), left in flight for reset
    add(2'b11,2'b00,2'b00,16'h0010,16'h0020,16'h0,16'h0,16'h0,
        2'b10,2'b00,16'h0,1'b1,1'b0,16'h0020,16'h0);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[s]) begin
      req = tbl[s].req; lock = tbl[s].lock; we = tbl[s].we;
      addr = {tbl[s].a1, tbl[s].a0};
      wdata = {tbl[s].d1, tbl[s].d0};
      mem_rdata = tbl[s].mrd;
      @(negedge clk);
      chk("gnt", s, 16'(gnt), 16'(tbl[s].gnt));
      chk("rvalid", s, 16'(rvalid), 16'(tbl[s].rv));
      chk("rdata", s, rdata, tbl[s].rd);
      chk("mem_valid", s, 16'(mem_valid), 16'(tbl[s].mv));
      chk("mem_w_en", s, 16'(mem_w_en), 16'(tbl[s].mwe));
      chk("mem_addr", s, mem_addr, tbl[s].ma);
      chk("mem_wdata", s, mem_wdata, tbl[s].md);
      @(posedge clk);
      #1;
    end

    // reset mid-read: requests still asserted while reset goes low
    mem_rdata = 16'h7777;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gnt", 100, 16'(gnt), 16'h0);
    chk("rst_mem_valid", 100, 16'(mem_valid), 16'h0);
    chk("rst_mem_addr", 100, mem_addr, 16'h0);
    chk("rst_rvalid", 100, 16'(rvalid), 16'h0);
    chk("rst_rdata", 100, rdata, 16'h0);
    req = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_rvalid", 101 + c, 16'(rvalid), 16'h0);
      chk("post_rst_rdata", 101 + c, rdata, 16'h0);
    end
    req = 2'b11;
    addr = {16'h0020, 16'h0010};
    #1;
    chk("post_rst_gnt", 104, 16'(gnt), 16'h0001);
    chk("post_rst_addr", 104, mem_addr, 16'h0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
